// File: rtl/AHB_package.sv
// Shared AHB-Lite encodings and the master/slave signal bundles.
package AHB_package;

  localparam int unsigned AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [1:0]            htrans;
    logic [AHB_DATA_W-1:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;
  } slv_send_type;

  // True when the byte span starting at offs runs past the next 1 KB boundary.
  function automatic logic crosses_1k(input logic [9:0] offs, input logic [9:0] span);
    logic [10:0] sum;
    sum = {1'b0, offs} + {1'b0, span};
    return sum[10];
  endfunction

endpackage

// File: rtl/renas_ahb_master_if.sv
// AHB-Lite master/slave signal pair bundled for the initiator and its slave side.
interface renas_ahb_master_if;
  import AHB_package::*;

  mas_send_type ahb_out;
  slv_send_type ahb_in;

  modport master (output ahb_out, input ahb_in);
  modport slave  (input ahb_out, output ahb_in);
endinterface

// File: rtl/renas_ahb_addr_gen.sv
// Beat counter and address incrementer for one request, with burst type and
// 1 KB boundary / last-beat flags.
module renas_ahb_addr_gen
  import AHB_package::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BEATS = 4,
  localparam int unsigned LEN_W    = $clog2(MAX_BEATS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [2:0]        hburst_o,
  output logic              last_o,
  output logic              boundary_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        burst_q;
  logic [2:0]        burst_d;

  // INCR4 only for a full 4-beat burst that stays inside one 1 KB page.
  always_comb begin
    burst_d = HBURST_INCR;
    if (len_i == '0) begin
      burst_d = HBURST_SINGLE;
    end else if (32'(len_i) == 32'd3 &&
                 !crosses_1k(start_addr_i[9:0], 10'({len_i, 2'b00}))) begin
      burst_d = HBURST_INCR4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else if (load_i) begin
      addr_q  <= start_addr_i;
      cnt_q   <= '0;
      len_q   <= len_i;
      burst_q <= burst_d;
    end else if (adv_i) begin
      addr_q  <= addr_q + ADDR_W'(4);
      cnt_q   <= cnt_q + LEN_W'(1);
    end
  end

  assign addr_o     = addr_q;
  assign hburst_o   = burst_q;
  assign last_o     = (cnt_q == len_q);
  assign boundary_o = (addr_q[9:0] == '0);

endmodule

// File: rtl/renas_ahb_master.sv
// AHB-Lite initiator: turns a single/burst client request into pipelined
// address and data phases, with wait-state, ERROR and 1 KB split handling.
module renas_ahb_master
  import AHB_package::*;
#(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned MAX_BEATS   = 4
) (
  input  logic                         clk_l2,
  input  logic                         rst,
  input  logic                         req,
  input  logic [DATA_LENGTH-1:0]       req_addr,
  input  logic                         req_write,
  input  logic [$clog2(MAX_BEATS)-1:0] req_len,
  input  logic [DATA_LENGTH-1:0]       req_wdata,
  output logic                         wdata_rd,
  output logic [DATA_LENGTH-1:0]       rdata,
  output logic                         rdata_valid,
  output logic                         done,
  output logic                         err,
  output logic                         busy,
  output mas_send_type                 ahb_out,
  input  slv_send_type                 ahb_in
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DONE} state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   aphase_q, aphase_d;
  logic   write_q;
  logic   rvalid_q;
  logic [DATA_LENGTH-1:0] rdata_q;
  logic [DATA_LENGTH-1:0] hwdata_q;

  logic [DATA_LENGTH-1:0] beat_addr;
  logic [2:0]             beat_burst;
  logic                   beat_last;
  logic                   beat_boundary;

  logic hready, hresp_err;
  logic load, addr_phase, addr_accept, adv, read_beat;

  assign hready    = ahb_in.hreadyout;
  assign hresp_err = (ahb_in.hresp == HRESP_ERROR);

  // An ERROR response withdraws the pipelined address phase in the same cycle.
  assign addr_phase  = (state_q == ADDR) ||
                       (state_q == DATA && aphase_q && !hresp_err);
  assign addr_accept = addr_phase && hready;
  assign adv         = addr_accept && !beat_last;
  assign load        = (state_q == IDLE) && req && (req_addr[1:0] == 2'b00);
  assign read_beat   = (state_q == DATA) && hready && !hresp_err && !write_q;
  assign wdata_rd    = addr_accept && write_q;

  renas_ahb_addr_gen #(
    .ADDR_W    (DATA_LENGTH),
    .MAX_BEATS (MAX_BEATS)
  ) u_addr_gen (
    .clk_i        (clk_l2),
    .rst_i        (rst),
    .load_i       (load),
    .adv_i        (adv),
    .start_addr_i (req_addr),
    .len_i        (req_len),
    .addr_o       (beat_addr),
    .hburst_o     (beat_burst),
    .last_o       (beat_last),
    .boundary_o   (beat_boundary)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    aphase_d = aphase_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (req_addr[1:0] == 2'b00) begin
            state_d  = ADDR;
            err_d    = 1'b0;
            aphase_d = 1'b1;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      ADDR: begin
        if (hready) begin
          state_d  = DATA;
          aphase_d = !beat_last;
        end
      end
      DATA: begin
        if (hresp_err) begin
          err_d   = 1'b1;
          state_d = hready ? DONE : ERR;
        end else if (hready) begin
          if (aphase_q) aphase_d = !beat_last;
          else          state_d  = DONE;
        end
      end
      ERR: begin
        if (hready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      aphase_q <= 1'b0;
      write_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      aphase_q <= aphase_d;
      rvalid_q <= read_beat;
      if (load)      write_q  <= req_write;
      if (read_beat) rdata_q  <= ahb_in.hrdata;
      if (wdata_rd)  hwdata_q <= req_wdata;
    end
  end

  always_comb begin
    ahb_out        = '0;
    ahb_out.hwdata = hwdata_q;
    if (state_q == ADDR || state_q == DATA) begin
      ahb_out.haddr  = beat_addr;
      ahb_out.hwrite = write_q;
      ahb_out.hsize  = HSIZE_WORD;
      ahb_out.hburst = beat_burst;
    end
    if (addr_phase) begin
      ahb_out.htrans = (state_q == ADDR || beat_boundary) ? HTRANS_NONSEQ : HTRANS_SEQ;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = (state_q == DONE);
  assign err         = (state_q == DONE) && err_q;
  assign busy        = (state_q == ADDR) || (state_q == DATA) || (state_q == ERR);

endmodule

// File: tb/tb_renas_ahb_master.sv
// Directed bench for renas_ahb_master with a behavioural AHB slave and
// queue-based scoreboard for address phases and read data.
module tb_renas_ahb_master;
  import AHB_package::*;

  logic        clk_l2 = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic        wdata_rd;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        busy;

  renas_ahb_master_if bus();

  renas_ahb_master #(.DATA_LENGTH(32), .MAX_BEATS(4)) dut (
    .clk_l2      (clk_l2),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .wdata_rd    (wdata_rd),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .ahb_out     (bus.ahb_out),
    .ahb_in      (bus.ahb_in)
  );

  always #5 clk_l2 = ~clk_l2;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] exp_addr[$];
  logic [1:0]  exp_trans[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] wlist[4];

  int          aphase_cnt, rvalid_cnt, wrd_cnt, wrd_idx, beat_idx, exp_aphase;
  bit          dp_valid, dp_write;
  logic [31:0] dp_addr;
  int          dp_beat;
  int          wait_beat, wait_left, err_beat, err_stage;
  logic [2:0]  exp_burst;
  logic        exp_write;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h400) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_zero(input string tag);
    n_cmp++;
    assert (bus.ahb_out === '0) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected 0", tag, bus.ahb_out);
    end
  endtask

  task automatic slave_idle();
    bus.ahb_in.hreadyout = 1'b1;
    bus.ahb_in.hresp     = HRESP_OKAY;
    bus.ahb_in.hrdata    = '0;
  endtask

  task automatic start(input logic [31:0] addr, input bit wr, input int len,
                       input logic [2:0] burst, input int wb, input int wn, input int eb);
    logic [31:0] a;
    @(posedge clk_l2); #1;
    exp_addr.delete(); exp_trans.delete(); exp_rdata.delete();
    aphase_cnt = 0; rvalid_cnt = 0; wrd_cnt = 0; wrd_idx = 0; beat_idx = 0;
    dp_valid = 0; dp_write = 0; dp_addr = '0; dp_beat = 0; err_stage = 0;
    wait_beat = wb; wait_left = wn; err_beat = eb;
    exp_burst = burst; exp_write = wr;
    if (addr[1:0] == 2'b00) begin
      for (int k = 0; k <= len; k++) begin
        a = addr + 32'(4 * k);
        if (eb < 0 || k <= eb) begin
          exp_addr.push_back(a);
          exp_trans.push_back((k == 0 || a[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ);
        end
      end
    end
    exp_aphase = exp_addr.size();
    slave_idle();
    req_addr = addr; req_write = wr; req_len = 2'(len); req_wdata = wlist[0]; req = 1'b1;
  endtask

  task automatic run(input int max_cyc, input bit expect_done, input bit exp_err, input int exp_cyc);
    bit fin = 0;
    bit wr_adv = 0;
    bit err_first;
    int cyc = 0;
    while (!fin && cyc < max_cyc) begin
      @(posedge clk_l2); #1;
      cyc++;
      req = 1'b0;
      if (wr_adv) begin wrd_idx++; wr_adv = 0; end
      req_wdata = wlist[wrd_idx % 4];
      if (rdata_valid) begin
        rvalid_cnt++;
        if (exp_rdata.size() != 0) chk("rdata", rdata, exp_rdata.pop_front());
      end
      if (done) begin
        fin = 1;
        chk("done_cycle", cyc, exp_cyc);
        chk("done_err", 32'(err), 32'(exp_err));
        chk("busy_at_done", 32'(busy), 0);
      end else begin
        chk("busy", 32'(busy), 1);
        err_first = 0;
        slave_idle();
        if (dp_valid) begin
          if (dp_beat == err_beat) begin
            bus.ahb_in.hresp = HRESP_ERROR;
            if (err_stage == 0) begin
              bus.ahb_in.hreadyout = 1'b0; err_stage = 1; err_first = 1;
            end
          end else if (dp_beat == wait_beat && wait_left > 0) begin
            bus.ahb_in.hreadyout = 1'b0; wait_left--;
          end else begin
            bus.ahb_in.hrdata = rd_val(dp_addr);
          end
        end
        #1;
        if (err_first) chk("err_cancel_htrans", 32'(bus.ahb_out.htrans), 32'(HTRANS_IDLE));
        if (bus.ahb_out.htrans != HTRANS_IDLE && exp_addr.size() != 0) begin
          chk("haddr", bus.ahb_out.haddr, exp_addr[0]);
          chk("htrans", 32'(bus.ahb_out.htrans), 32'(exp_trans[0]));
        end
        if (dp_valid && dp_write) chk("hwdata", bus.ahb_out.hwdata, wlist[dp_beat % 4]);
        if (wdata_rd) begin wrd_cnt++; wr_adv = 1; end
        if (dp_valid && bus.ahb_in.hreadyout) begin
          if (bus.ahb_in.hresp == HRESP_OKAY && !dp_write) exp_rdata.push_back(rd_val(dp_addr));
          dp_valid = 0;
        end
        if (bus.ahb_out.htrans[1] && bus.ahb_in.hreadyout) begin
          aphase_cnt++;
          chk("hburst", 32'(bus.ahb_out.hburst), 32'(exp_burst));
          chk("hsize", 32'(bus.ahb_out.hsize), 32'(HSIZE_WORD));
          chk("hwrite", 32'(bus.ahb_out.hwrite), 32'(exp_write));
          if (exp_addr.size() != 0) begin exp_addr.delete(0); exp_trans.delete(0); end
          dp_valid = 1; dp_addr = bus.ahb_out.haddr; dp_write = bus.ahb_out.hwrite;
          dp_beat = beat_idx; beat_idx++;
        end
      end
    end
    if (expect_done) chk("done_seen", 32'(fin), 1);
  endtask

  task automatic end_checks(input int exp_rv, input int exp_wrd);
    chk("aphase_count", aphase_cnt, exp_aphase);
    chk("rvalid_count", rvalid_cnt, exp_rv);
    chk("wdata_rd_count", wrd_cnt, exp_wrd);
    chk("rdata_queue_left", exp_rdata.size(), 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_addr = '0; req_write = 1'b0; req_len = '0; req_wdata = '0;
    wlist = '{32'd1, 32'd2, 32'd3, 32'd4};
    slave_idle();
    #12;
    chk_bus_zero("ahb_out_reset");
    chk("rdata_reset", rdata, 0);
    chk("rdata_valid_reset", 32'(rdata_valid), 0);
    chk("done_reset", 32'(done), 0);
    chk("err_reset", 32'(err), 0);
    chk("busy_reset", 32'(busy), 0);
    rst = 1'b0;

    // single read, zero-wait
    start(32'h400, 1'b0, 0, HBURST_SINGLE, -1, 0, -1);
    run(20, 1'b1, 1'b0, 3);
    end_checks(1, 0);

    // 4-beat write, two wait states on the second beat
    start(32'h800, 1'b1, 3, HBURST_INCR4, 1, 2, -1);
    run(30, 1'b1, 1'b0, 8);
    end_checks(0, 4);

    // 1 KB split read
    start(32'hBF8, 1'b0, 3, HBURST_INCR, -1, 0, -1);
    run(30, 1'b1, 1'b0, 6);
    end_checks(4, 0);

    // ERROR on the second beat of a 4-beat read
    start(32'h100, 1'b0, 3, HBURST_INCR4, -1, 0, 1);
    run(30, 1'b1, 1'b1, 5);
    end_checks(1, 0);

    // misaligned request is rejected
    start(32'h402, 1'b0, 0, HBURST_SINGLE, -1, 0, -1);
    run(10, 1'b1, 1'b1, 1);
    end_checks(0, 0);
    chk("htrans_misaligned", 32'(bus.ahb_out.htrans), 32'(HTRANS_IDLE));

    // asynchronous reset during the second beat, then a normal request
    start(32'h200, 1'b0, 3, HBURST_INCR4, -1, 0, -1);
    run(3, 1'b0, 1'b0, 0);
    #1 rst = 1'b1;
    #1;
    chk_bus_zero("ahb_out_async_reset");
    chk("busy_async_reset", 32'(busy), 0);
    chk("done_async_reset", 32'(done), 0);
    chk("rdata_valid_async_reset", 32'(rdata_valid), 0);
    #3 rst = 1'b0;
    start(32'h400, 1'b0, 0, HBURST_SINGLE, -1, 0, -1);
    run(20, 1'b1, 1'b0, 3);
    end_checks(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/renas_ahb_master.md
# renas_ahb_master

AHB-Lite initiator that turns a simple client request (single word or incrementing burst of up to 4 words) into pipelined AHB address/data phases on a `mas_send_type` / `slv_send_type` port pair. It is the master-side counterpart to the `renas_memory` slave and sits between a cache-refill / load-store client and the AHB interconnect. It handles slave wait states, ERROR responses and 1 KB boundary splitting.

## Interface
- `DATA_LENGTH`, 32, data and address width.
- `MAX_BEATS`, 4, maximum beats per request; `req_len` is `$clog2(MAX_BEATS)` bits wide.
- `clk_l2`, in, 1, bus clock; every flop is clocked on its rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `req`, in, 1, request valid; sampled only in IDLE.
- `req_addr`, in, 32, start byte address; must be word-aligned.
- `req_write`, in, 1, 1 = write, 0 = read.
- `req_len`, in, 2, number of beats minus 1.
- `req_wdata`, in, 32, write data for the current beat.
- `wdata_rd`, out, 1, combinational; high when `req_wdata` is consumed this edge, and the client presents the next word after it.
- `rdata`, out, 32, registered read data.
- `rdata_valid`, out, 1, one-cycle pulse per read beat.
- `done`, out, 1, one-cycle pulse at request completion, OK or error.
- `err`, out, 1, qualifies `done`; 1 = error or rejected request.
- `busy`, out, 1, high from request acceptance until `done`.
- `ahb_out`, out, `mas_send_type`, carries `haddr`, `hwrite`, `hsize`, `hburst`, `htrans`, `hwdata`.
- `ahb_in`, in, `slv_send_type`, carries `hrdata`, `hreadyout`, `hresp`.

## Operation
- FSM states: IDLE, ADDR, DATA, ERR, DONE.
- **IDLE:**
  - `req`=1 with `req_addr[1:0]`=0: latch the request and go to ADDR.
  - `req`=1 with `req_addr[1:0]`≠0: go to DONE with `err`=1 and issue no AHB transfer.
- **ADDR:**
  - Drive the first beat: `htrans`=NONSEQ, `hsize`=WORD, `hwrite`=`req_write`.
  - `hburst` is SINGLE when `req_len`=0.
  - `hburst` is INCR4 when `req_len`=3 and no 1 KB crossing.
  - `hburst` is INCR otherwise.
  - When `hreadyout`=1, go to DATA.
- **DATA (pipelined):**
  - While the previous beat is in its data phase, drive the next beat with `htrans`=SEQ and `haddr`+4.
  - A beat whose `haddr[9:0]`=0 (not the first beat) is driven as NONSEQ.
  - After the last address phase is accepted, drive `htrans`=IDLE.
  - Beat counter and address advance only on edges where `hreadyout`=1.
- **Write data:** `wdata_rd` = write address phase active && `hreadyout`. On that edge `hwdata` is loaded from `req_wdata` and held through the data phase.
- **Read data:** on each data-phase edge with `hreadyout`=1, register `hrdata` into `rdata` and pulse `rdata_valid`.
- **ERR:**
  - On `hresp`=ERROR with `hreadyout`=0, drive `htrans`=IDLE in that same cycle (cancel the pipelined beat).
  - On the second ERROR cycle (`hreadyout`=1), go to DONE with `err`=1 and issue no further beats.
- **DONE:** pulse `done` for one cycle, clear `busy`, return to IDLE. A new request is accepted no earlier than the cycle after `done`.
- `haddr` arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- **Reset:** all of `ahb_out` is 0 (`htrans`=IDLE); `rdata`, `rdata_valid`, `done`, `err`, `busy` are 0; FSM is in IDLE.
- **Reset mid-transfer:** the above values apply asynchronously, and the request is dropped with no `done`.
- **Single read, zero-wait slave:**
  - `req` sampled at edge E0; NONSEQ is visible after E0.
  - Address accepted at E1.
  - Data sampled at E2.
  - `rdata_valid`, `done` and `busy`=0 occur in the cycle after E2.
- **4-beat burst, zero-wait:** address phases on E0..E3 (accepted E1..E4), `rdata_valid` in the 4 cycles after E2..E5, `done` with the last `rdata_valid`.
- **Write:** `done` is asserted in the cycle after the last data-phase edge with `hreadyout`=1.
- **Wait states:** every wait cycle stretches the current phase by one cycle; `ahb_out` is held stable.

## Structure
- `AHB_package` holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HBURST codes (SINGLE/INCR/INCR4);
  - HSIZE WORD;
  - HRESP OKAY/ERROR.
- These constants are added there if missing.
- The FSM state enum stays local to the module.
- One sub-module: `renas_ahb_addr_gen`, the beat counter plus the address incrementer and 1 KB-boundary / last-beat flags.

## Test plan
- **Single read:** zero-wait slave, `req_addr`=0x400, `req_len`=0, `hrdata`=0xDEADBEEF → one NONSEQ/SINGLE at 0x400; `rdata`=0xDEADBEEF with `rdata_valid` and `done`, `err`=0.
- **4-beat write with wait:**
  - `req_addr`=0x800, `req_len`=3, data 1..4, slave inserts 2 wait states on beat 2.
  - Required: INCR4 with haddr 0x800/804/808/80C, htrans N,S,S,S, hwdata 1..4.
  - Required: `ahb_out` is stable during the waits and exactly 4 `wdata_rd` pulses occur.
- **1 KB split:** read `req_addr`=0xBF8, `req_len`=3 → hburst INCR; htrans N,S,N,S at 0xBF8/BFC/C00/C04; 4 `rdata_valid` pulses.
- **Error mid-burst:** ERROR on beat 2 of a 4-beat read → htrans=IDLE in the first ERROR cycle, no beat 3/4 address, `done`+`err`=1, only one `rdata_valid`.
- **Misaligned request:** `req_addr`=0x402 → `done`+`err` the next cycle, `htrans` stays IDLE throughout.
- **Reset mid-burst:** assert `rst` during beat 2 → `ahb_out`=0 and `busy`=0 immediately; the next request completes normally.
